// File: rtl/rom_access_ctrl.sv
// Two-port round-robin front end for a single combinational ROM, with
// programmable wait states and per-port valid/ready response registers.
module rom_access_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_a_req,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  output logic                  o_a_gnt,
  output logic                  o_a_rvalid,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  input  logic                  i_a_rready,
  input  logic                  i_b_req,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  output logic                  o_b_gnt,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  input  logic                  i_b_rready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  prefer_b_q;
  logic                  cur_b_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

  logic                  elig_a, elig_b;
  logic                  gnt_a, gnt_b, gnt_any;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  cap_a, cap_b;

  always_comb begin
    elig_a   = i_a_req && (!a_rvalid_q || i_a_rready);
    elig_b   = i_b_req && (!b_rvalid_q || i_b_rready);
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    // Grants are masked during reset so every output reads 0 while it is held.
    if (state_q == ST_IDLE && !i_reset) begin
      if (elig_a && (!elig_b || !prefer_b_q)) gnt_a = 1'b1;
      else if (elig_b)                         gnt_b = 1'b1;
    end
    gnt_any  = gnt_a | gnt_b;
    gnt_addr = gnt_b ? i_b_addr : i_a_addr;
    o_mem_addr = gnt_any ? gnt_addr : addr_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    cap_a   = 1'b0;
    cap_b   = 1'b0;
    if (WAIT_STATES == 0) begin
      cap_a = gnt_a;
      cap_b = gnt_b;
    end else if (gnt_any) begin
      state_d = ST_WAIT;
      cnt_d   = WS;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = ST_IDLE;
        cap_a   = !cur_b_q;
        cap_b   = cur_b_q;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      prefer_b_q <= 1'b0;
      cur_b_q    <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt_any) begin
        prefer_b_q <= gnt_a;
        cur_b_q    <= gnt_b;
        addr_q     <= gnt_addr;
      end
    end
  end

  // A capture on the same edge as an accept keeps rvalid high with fresh data.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      a_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
    end else begin
      if (cap_a) begin
        a_rvalid_q <= 1'b1;
        a_rdata_q  <= i_mem_rdata;
      end else if (a_rvalid_q && i_a_rready) begin
        a_rvalid_q <= 1'b0;
      end
      if (cap_b) begin
        b_rvalid_q <= 1'b1;
        b_rdata_q  <= i_mem_rdata;
      end else if (b_rvalid_q && i_b_rready) begin
        b_rvalid_q <= 1'b0;
      end
    end
  end

  assign o_a_gnt    = gnt_a;
  assign o_b_gnt    = gnt_b;
  assign o_a_rvalid = a_rvalid_q;
  assign o_a_rdata  = a_rdata_q;
  assign o_b_rvalid = b_rvalid_q;
  assign o_b_rdata  = b_rdata_q;
  assign o_busy     = (state_q == ST_WAIT);

endmodule

// File: tb/tb_rom_access_ctrl.sv
// Directed bench: one instance with no wait states, one with three, sharing clock and reset.
module tb_rom_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        p0_a_req = 0, p0_b_req = 0, p0_a_rready = 0, p0_b_rready = 0;
  logic [31:0] p0_a_addr = 0, p0_b_addr = 0;
  logic        p0_a_gnt, p0_b_gnt, p0_a_rvalid, p0_b_rvalid, p0_busy;
  logic [31:0] p0_a_rdata, p0_b_rdata, p0_mem_addr, p0_mem_rdata;

  logic        p3_a_req = 0, p3_b_req = 0, p3_a_rready = 0, p3_b_rready = 0;
  logic [31:0] p3_a_addr = 0, p3_b_addr = 0;
  logic        p3_a_gnt, p3_b_gnt, p3_a_rvalid, p3_b_rvalid, p3_busy;
  logic [31:0] p3_a_rdata, p3_b_rdata, p3_mem_addr, p3_mem_rdata;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | a);
  endfunction

  assign p0_mem_rdata = rom(p0_mem_addr);
  assign p3_mem_rdata = rom(p3_mem_addr);

  rom_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(0)) dut0 (
    .i_clock(clk), .i_reset(rst),
    .i_a_req(p0_a_req), .i_a_addr(p0_a_addr), .o_a_gnt(p0_a_gnt),
    .o_a_rvalid(p0_a_rvalid), .o_a_rdata(p0_a_rdata), .i_a_rready(p0_a_rready),
    .i_b_req(p0_b_req), .i_b_addr(p0_b_addr), .o_b_gnt(p0_b_gnt),
    .o_b_rvalid(p0_b_rvalid), .o_b_rdata(p0_b_rdata), .i_b_rready(p0_b_rready),
    .o_mem_addr(p0_mem_addr), .i_mem_rdata(p0_mem_rdata), .o_busy(p0_busy)
  );

  rom_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(3)) dut3 (
    .i_clock(clk), .i_reset(rst),
    .i_a_req(p3_a_req), .i_a_addr(p3_a_addr), .o_a_gnt(p3_a_gnt),
    .o_a_rvalid(p3_a_rvalid), .o_a_rdata(p3_a_rdata), .i_a_rready(p3_a_rready),
    .i_b_req(p3_b_req), .i_b_addr(p3_b_addr), .o_b_gnt(p3_b_gnt),
    .o_b_rvalid(p3_b_rvalid), .o_b_rdata(p3_b_rdata), .i_b_rready(p3_b_rready),
    .o_mem_addr(p3_mem_addr), .i_mem_rdata(p3_mem_rdata), .o_busy(p3_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each window opens 2 time units after a rising edge; inputs change there.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] p0_outs();
    return {16'd0, p0_a_gnt, p0_b_gnt, p0_a_rvalid, p0_b_rvalid, p0_busy,
            |p0_a_rdata, |p0_b_rdata, |p0_mem_addr, 8'd0};
  endfunction

  function automatic logic [31:0] p3_outs();
    return {16'd0, p3_a_gnt, p3_b_gnt, p3_a_rvalid, p3_b_rvalid, p3_busy,
            |p3_a_rdata, |p3_b_rdata, |p3_mem_addr, 8'd0};
  endfunction

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_p0", p0_outs(), 32'd0);
    chk("reset_p3", p3_outs(), 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      chk("idle_p0", p0_outs(), 32'd0);
      chk("idle_p3", p3_outs(), 32'd0);
    end

    // Single A read, no wait states
    cyc();
    p0_a_req = 1; p0_a_addr = 32'h10;
    #1;
    chk("ws0_gnt_a", {31'd0, p0_a_gnt}, 32'd1);
    chk("ws0_mem_addr", p0_mem_addr, 32'h10);
    cyc();
    p0_a_req = 0;
    #1;
    chk("ws0_rvalid", {31'd0, p0_a_rvalid}, 32'd1);
    chk("ws0_rdata", p0_a_rdata, 32'hDEADBEEF);
    chk("ws0_no_regrant", {31'd0, p0_a_gnt}, 32'd0);
    cyc();
    p0_a_rready = 1;
    cyc();
    p0_a_rready = 0;
    #1;
    chk("ws0_rvalid_clr", {31'd0, p0_a_rvalid}, 32'd0);
    chk("ws0_addr_hold", p0_mem_addr, 32'h10);

    // Both ports streaming; A was granted last, so B takes the first tie
    cyc();
    p0_a_req = 1; p0_a_addr = 32'h20; p0_a_rready = 1;
    p0_b_req = 1; p0_b_addr = 32'h30; p0_b_rready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_gnt", {30'd0, p0_a_gnt, p0_b_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_mem_addr", p0_mem_addr, (i % 2 == 0) ? 32'h30 : 32'h20);
      if (i % 2 == 1) chk("rr_b_data", p0_b_rdata, 32'hC0DE0030);
      if (i >= 2 && i % 2 == 0) chk("rr_a_data", p0_a_rdata, 32'hC0DE0020);
      cyc();
    end
    p0_a_req = 0; p0_b_req = 0;
    cyc();
    p0_a_rready = 0; p0_b_rready = 0;
    #1;
    chk("rr_drained", {30'd0, p0_a_rvalid, p0_b_rvalid}, 32'd0);

    // Three wait states, B reads 0x4 while A arrives one cycle later
    cyc();
    p3_b_req = 1; p3_b_addr = 32'h4;
    #1;
    chk("ws3_gnt_b", {31'd0, p3_b_gnt}, 32'd1);
    chk("ws3_addr_n", p3_mem_addr, 32'h4);
    chk("ws3_busy_n", {31'd0, p3_busy}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      p3_b_req = 0; p3_a_req = 1; p3_a_addr = 32'h10;
      #1;
      chk("ws3_busy", {31'd0, p3_busy}, 32'd1);
      chk("ws3_addr_hold", p3_mem_addr, 32'h4);
      chk("ws3_no_gnt", {30'd0, p3_a_gnt, p3_b_gnt}, 32'd0);
      chk("ws3_no_rvalid", {31'd0, p3_b_rvalid}, 32'd0);
    end
    cyc();
    #1;
    chk("ws3_busy_off", {31'd0, p3_busy}, 32'd0);
    chk("ws3_b_rvalid", {31'd0, p3_b_rvalid}, 32'd1);
    chk("ws3_b_rdata", p3_b_rdata, 32'hC0DE0004);
    chk("ws3_gnt_a", {31'd0, p3_a_gnt}, 32'd1);
    chk("ws3_addr_a", p3_mem_addr, 32'h10);
    cyc();
    p3_a_req = 0;
    cyc();
    cyc();
    cyc();
    #1;
    chk("ws3_a_rvalid", {31'd0, p3_a_rvalid}, 32'd1);
    chk("ws3_a_rdata", p3_a_rdata, 32'hDEADBEEF);

    // Backpressure on A, B keeps being served
    cyc();
    p0_a_req = 1; p0_a_addr = 32'h20;
    #1;
    chk("bp_gnt_a", {31'd0, p0_a_gnt}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      p0_a_addr = 32'h10;
      p0_b_req = 1; p0_b_addr = 32'h30; p0_b_rready = 1;
      #1;
      chk("bp_a_held", {31'd0, p0_a_gnt}, 32'd0);
      chk("bp_a_rdata", p0_a_rdata, 32'hC0DE0020);
      chk("bp_b_gnt", {31'd0, p0_b_gnt}, 32'd1);
    end
    cyc();
    p0_a_rready = 1;
    #1;
    chk("bp_a_regnt", {30'd0, p0_a_gnt, p0_b_gnt}, 32'd2);
    chk("bp_a_addr", p0_mem_addr, 32'h10);
    cyc();
    p0_a_req = 0; p0_b_req = 0; p0_a_rready = 0;
    #1;
    chk("bp_a_new_valid", {31'd0, p0_a_rvalid}, 32'd1);
    chk("bp_a_new_data", p0_a_rdata, 32'hDEADBEEF);

    // Reset in the middle of a wait-state access
    cyc();
    p3_a_rready = 1; p3_b_rready = 1;
    cyc();
    p3_a_rready = 0; p3_b_rready = 0;
    p3_a_req = 1; p3_a_addr = 32'h20; p3_b_req = 1; p3_b_addr = 32'h30;
    #1;
    chk("rst_pre_gnt", {30'd0, p3_a_gnt, p3_b_gnt}, 32'd1);
    cyc();
    p3_a_req = 0; p3_b_req = 0;
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_async_p3", p3_outs(), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk("rst_no_rvalid", p3_outs(), 32'd0);
    end
    cyc();
    p3_a_req = 1; p3_b_req = 1;
    #1;
    chk("rst_tie_a", {30'd0, p3_a_gnt, p3_b_gnt}, 32'd2);
    cyc();
    p3_a_req = 0; p3_b_req = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
